// File: rtl/rle_packer.sv
// rtl/rle_packer.sv - run-length packer: collapses equal consecutive samples into {count-1, value} words
// One registered output slot; pending-last and pending-flush flags drain through it when it frees.
module rle_packer #(
  parameter int dataw = 32,
  parameter int cntw  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [dataw-1:0]       slave_tdata,
  input  logic                   slave_tvalid,
  input  logic                   slave_tlast,
  output logic                   slave_tready,
  output logic [cntw+dataw-1:0]  master_tdata,
  output logic                   master_tvalid,
  output logic                   master_tlast,
  input  logic                   master_tready,
  input  logic                   enable,
  input  logic                   flush,
  output logic [31:0]            word_count
);

  logic                  run_valid_q, run_valid_d;
  logic [dataw-1:0]      run_val_q, run_val_d;
  logic [cntw-1:0]       run_cnt_q, run_cnt_d;
  logic                  pend_last_q, pend_last_d;
  logic                  flush_pend_q, flush_pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [cntw+dataw-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic [31:0]           word_count_q, word_count_d;

  logic slot_free;
  logic accept;
  logic run_sat;
  logic extend;

  assign slot_free    = !out_valid_q || master_tready;
  assign slave_tready = !reset && slot_free && !pend_last_q && !flush_pend_q && !flush;
  assign accept       = slave_tvalid && slave_tready;
  assign run_sat      = &run_cnt_q;
  assign extend       = run_valid_q && (slave_tdata == run_val_q) && !run_sat && enable;

  assign master_tvalid = out_valid_q;
  assign master_tdata  = out_data_q;
  assign master_tlast  = out_last_q;
  assign word_count    = word_count_q;

  always_comb begin
    run_valid_d  = run_valid_q;
    run_val_d    = run_val_q;
    run_cnt_d    = run_cnt_q;
    pend_last_d  = pend_last_q;
    flush_pend_d = flush_pend_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    word_count_d = word_count_q;

    if (out_valid_q && master_tready) begin
      out_valid_d  = 1'b0;
      word_count_d = word_count_q + 32'd1;
    end

    if (accept) begin
      if (!run_valid_q) begin
        // Bypass samples and single-sample last beats never linger as an open run
        if (!enable || slave_tlast) begin
          out_valid_d = 1'b1;
          out_data_d  = {cntw'(0), slave_tdata};
          out_last_d  = slave_tlast;
        end else begin
          run_valid_d = 1'b1;
          run_val_d   = slave_tdata;
          run_cnt_d   = '0;
        end
      end else if (extend) begin
        if (slave_tlast) begin
          out_valid_d = 1'b1;
          out_data_d  = {run_cnt_q + cntw'(1), slave_tdata};
          out_last_d  = 1'b1;
          run_valid_d = 1'b0;
        end else begin
          run_cnt_d = run_cnt_q + cntw'(1);
        end
      end else begin
        out_valid_d = 1'b1;
        out_data_d  = {run_cnt_q, run_val_q};
        out_last_d  = 1'b0;
        run_val_d   = slave_tdata;
        run_cnt_d   = '0;
        // The one-sample run just opened is the final word; it leaves via the pending path
        if (slave_tlast) begin
          pend_last_d = 1'b1;
        end
      end
    end else if ((pend_last_q || flush_pend_q) && slot_free) begin
      out_valid_d  = 1'b1;
      out_data_d   = {run_cnt_q, run_val_q};
      out_last_d   = 1'b1;
      run_valid_d  = 1'b0;
      pend_last_d  = 1'b0;
      flush_pend_d = 1'b0;
    end else if (flush && run_valid_q && !pend_last_q) begin
      flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_valid_q  <= 1'b0;
      run_val_q    <= '0;
      run_cnt_q    <= '0;
      pend_last_q  <= 1'b0;
      flush_pend_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      word_count_q <= '0;
    end else begin
      run_valid_q  <= run_valid_d;
      run_val_q    <= run_val_d;
      run_cnt_q    <= run_cnt_d;
      pend_last_q  <= pend_last_d;
      flush_pend_q <= flush_pend_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      word_count_q <= word_count_d;
    end
  end

endmodule

// File: tb/tb_rle_packer.sv
// tb/tb_rle_packer.sv - scoreboard bench for rle_packer (dataw=8, cntw=2)
module tb_rle_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  slave_tdata;
  logic        slave_tvalid;
  logic        slave_tlast;
  logic        slave_tready;
  logic [9:0]  master_tdata;
  logic        master_tvalid;
  logic        master_tlast;
  logic        master_tready;
  logic        enable;
  logic        flush;
  logic [31:0] word_count;

  logic [10:0] exp_q[$];
  logic [10:0] obs_q[$];
  int total = 0;
  int bad = 0;
  int exp_words = 0;
  bit rand_rdy = 1'b0;

  always #5 clk = ~clk;

  rle_packer #(.dataw(8), .cntw(2)) dut (
    .clk(clk), .reset(reset),
    .slave_tdata(slave_tdata), .slave_tvalid(slave_tvalid), .slave_tlast(slave_tlast),
    .slave_tready(slave_tready),
    .master_tdata(master_tdata), .master_tvalid(master_tvalid), .master_tlast(master_tlast),
    .master_tready(master_tready),
    .enable(enable), .flush(flush), .word_count(word_count)
  );

  always @(negedge clk) begin
    if (!reset && master_tvalid && master_tready)
      obs_q.push_back({master_tlast, master_tdata});
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) master_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic expect_word(input logic [1:0] cnt, input logic [7:0] d, input logic last);
    exp_q.push_back({last, cnt, d});
    exp_words++;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    int n;
    logic ok;
    n = 0;
    ok = 1'b0;
    slave_tdata = d;
    slave_tvalid = 1'b1;
    slave_tlast = last;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = slave_tready;
      tick();
      n++;
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout got=no_accept want=accept data=%h", d);
    end
    slave_tvalid = 1'b0;
    slave_tlast = 1'b0;
  endtask

  task automatic wait_words();
    int n;
    n = 0;
    while (obs_q.size() < exp_q.size() && n < 300) begin
      tick();
      n++;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    slave_tdata = '0; slave_tvalid = 1'b0; slave_tlast = 1'b0;
    master_tready = 1'b1; enable = 1'b1; flush = 1'b0;
    tick(); tick();
    @(negedge clk);
    total++;
    if ({slave_tready, master_tvalid, master_tlast} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000", {slave_tready, master_tvalid, master_tlast});
    end
    total++;
    if (master_tdata !== 10'd0) begin
      bad++;
      $display("FAIL reset_tdata got=%h want=0", master_tdata);
    end
    total++;
    if (word_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_word_count got=%0d want=0", word_count);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    enable = 1'b1;
    master_tready = 1'b1;
    send(8'd5, 1'b0); send(8'd5, 1'b0); send(8'd5, 1'b0);
    expect_word(2'd2, 8'd5, 1'b0);
    send(8'd7, 1'b1);
    expect_word(2'd0, 8'd7, 1'b1);
    wait_words();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      logic [10:0] o;
      o = (i < obs_q.size()) ? obs_q[i] : 11'bx;
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL basic_word%0d got=%h want=%h", i, o, exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    total++;
    if (word_count !== 32'd2) begin
      bad++;
      $display("FAIL basic_word_count got=%0d want=2", word_count);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) begin
      send(8'hA, 1'b0);
      if (i == 4) expect_word(2'd3, 8'hA, 1'b0);
    end
    expect_word(2'd3, 8'hA, 1'b0);
    send(8'hB, 1'b1);
    expect_word(2'd0, 8'hB, 1'b1);
    wait_words();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL sat_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      logic [10:0] o;
      o = (i < obs_q.size()) ? obs_q[i] : 11'bx;
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL sat_word%0d got=%h want=%h", i, o, exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_bypass();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(8'd1, i == 2);
      expect_word(2'd0, 8'd1, i == 2);
    end
    wait_words();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL bypass_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      logic [10:0] o;
      o = (i < obs_q.size()) ? obs_q[i] : 11'bx;
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL bypass_word%0d got=%h want=%h", i, o, exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    enable = 1'b1;
  endtask

  task automatic test_flush();
    send(8'd4, 1'b0); send(8'd4, 1'b0);
    expect_word(2'd1, 8'd4, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    total++;
    if (slave_tready !== 1'b0) begin
      bad++;
      $display("FAIL flush_tready_pulse got=%b want=0", slave_tready);
    end
    tick();
    flush = 1'b0;
    @(negedge clk);
    total++;
    if (slave_tready !== 1'b0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL flush_tready_pend got=%b/%0d want=0/0", slave_tready, obs_q.size());
    end
    wait_words();
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL flush_word got=%0d words first=%h want=1 word %h", obs_q.size(), obs_q.size() ? obs_q[0] : 11'bx, exp_q[0]);
    end
    exp_q.delete(); obs_q.delete();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    repeat (5) tick();
    total++;
    if (obs_q.size() != 0 || word_count !== 32'(exp_words)) begin
      bad++;
      $display("FAIL flush_idle got=%0d words wc=%0d want=0 words wc=%0d", obs_q.size(), word_count, exp_words);
    end
    obs_q.delete();
  endtask

  task automatic test_backpressure();
    master_tready = 1'b0;
    send(8'd6, 1'b0); send(8'd6, 1'b0);
    send(8'd8, 1'b1);
    expect_word(2'd1, 8'd6, 1'b0);
    expect_word(2'd0, 8'd8, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if ({slave_tready, master_tvalid, master_tlast, master_tdata} !== {1'b0, 1'b1, 1'b0, 2'd1, 8'd6}) begin
        bad++;
        $display("FAIL stall_cycle%0d got=%b%b%b_%h want=010_106", i, slave_tready, master_tvalid, master_tlast, master_tdata);
      end
      tick();
    end
    master_tready = 1'b1;
    wait_words();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL stall_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      logic [10:0] o;
      o = (i < obs_q.size()) ? obs_q[i] : 11'bx;
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL stall_word%0d got=%h want=%h", i, o, exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    rand_rdy = 1'b1;
    send(8'd1, 1'b0); send(8'd2, 1'b0); send(8'd2, 1'b0);
    expect_word(2'd0, 8'd1, 1'b0);
    send(8'd3, 1'b1);
    expect_word(2'd1, 8'd2, 1'b0);
    expect_word(2'd0, 8'd3, 1'b1);
    repeat (4) tick();
    rand_rdy = 1'b0;
    master_tready = 1'b1;
    wait_words();
    total++;
    if (obs_q.size() != exp_q.size()) begin
      bad++;
      $display("FAIL b2b_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      logic [10:0] o;
      o = (i < obs_q.size()) ? obs_q[i] : 11'bx;
      total++;
      if (o !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_word%0d got=%h want=%h", i, o, exp_q[i]);
      end
    end
    exp_q.delete(); obs_q.delete();
    total++;
    if (word_count !== 32'(exp_words)) begin
      bad++;
      $display("FAIL b2b_word_count got=%0d want=%0d", word_count, exp_words);
    end
  endtask

  task automatic test_reset_midrun();
    send(8'd9, 1'b0); send(8'd9, 1'b0);
    reset = 1'b1;
    tick();
    @(negedge clk);
    total++;
    if ({slave_tready, master_tvalid} !== 2'b00 || word_count !== 32'd0) begin
      bad++;
      $display("FAIL midrun_reset got=%b%b wc=%0d want=00 wc=0", slave_tready, master_tvalid, word_count);
    end
    reset = 1'b0;
    exp_words = 0;
    repeat (3) tick();
    total++;
    if (obs_q.size() != 0) begin
      bad++;
      $display("FAIL midrun_discard got=%0d words want=0", obs_q.size());
    end
    obs_q.delete();
    send(8'd3, 1'b1);
    expect_word(2'd0, 8'd3, 1'b1);
    wait_words();
    total++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      bad++;
      $display("FAIL midrun_word got=%0d words first=%h want=1 word %h", obs_q.size(), obs_q.size() ? obs_q[0] : 11'bx, exp_q[0]);
    end
    exp_q.delete(); obs_q.delete();
    total++;
    if (word_count !== 32'd1) begin
      bad++;
      $display("FAIL midrun_word_count got=%0d want=1", word_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_bypass();
    test_flush();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rle_packer.md
RLE_PACKER -- requirements
Module: rle_packer

Interface
REQ-001 SHALL have parameter dataw, default 32, sample width; equals the size of the upstream capture stream.
REQ-002 SHALL have parameter cntw, default 16, run-count field width; legal range 1..32.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port slave_tdata, input, dataw, sample from the capture FIFO master side.
REQ-006 SHALL have ports slave_tvalid (input, 1), slave_tlast (input, 1) and slave_tready (output, 1), forming the AXI-Stream slave handshake.
REQ-007 SHALL have port master_tdata, output, cntw+dataw; [cntw+dataw-1:dataw] = run count minus 1, [dataw-1:0] = sample value.
REQ-008 SHALL have ports master_tvalid (output, 1), master_tlast (output, 1) and master_tready (input, 1), forming the AXI-Stream master handshake.
REQ-009 SHALL have port enable, input, 1; 1 = compress, 0 = bypass, in which every sample becomes its own word.
REQ-010 SHALL have port flush, input, 1; a single-cycle request to close the open run with tlast set.
REQ-011 SHALL have port word_count, output, 32, number of master handshakes since reset; wraps modulo 2^32.

Function
REQ-012 SHALL hold an internal run: run_valid, run_val (dataw bits), run_cnt (cntw bits, equal to length-1), plus pend_last and flush_pend flags.
REQ-013 SHALL hold one registered output slot; the slot is free when master_tvalid=0 or (master_tvalid & master_tready).
REQ-014 SHALL drive slave_tready = slot free & !pend_last & !flush_pend & !flush; slave_tready SHALL be a combinational function of registered state and the inputs named.
REQ-015 SHALL treat an accepted beat as slave_tvalid & slave_tready; enable SHALL be sampled at acceptance.
REQ-016 On an accepted beat with !run_valid: SHALL open a run with run_val=d and run_cnt=0.
REQ-017 On an accepted beat that extends the run (run_valid, d==run_val, run_cnt<2^cntw-1, enable=1): SHALL increment run_cnt; no output word is produced.
REQ-018 On an accepted beat that breaks the run (run_valid and any of: d!=run_val, run_cnt saturated, enable=0): SHALL load the slot with {run_cnt, run_val} and tlast=0, then open a new run from d.
REQ-019 On an accepted beat with tlast=1 and no break: SHALL load the slot with the final run {count, d} and tlast=1, then clear run_valid.
REQ-020 On an accepted beat with tlast=1 that also breaks the run: SHALL emit the old run per REQ-018 and set pend_last; when the slot next frees, SHALL emit {0, d} with tlast=1 and clear pend_last and run_valid.
REQ-021 In bypass (enable=0) with no open run: SHALL emit {0, d} in the cycle after acceptance, so the run never persists past one sample.
REQ-022 Flush with run_valid=1 SHALL set flush_pend; when the slot frees, SHALL emit {run_cnt, run_val} with tlast=1 and clear run_valid and flush_pend.
REQ-023 Flush with no open run, or while pend_last is set, SHALL be ignored and produce no word.
REQ-024 Output latency SHALL be 1 cycle: the slot becomes valid on the clock edge that accepts the terminating beat or services the pending flag.
REQ-025 master_tvalid, master_tdata and master_tlast SHALL remain stable while master_tvalid=1 & master_tready=0.
REQ-026 word_count SHALL increment on every master_tvalid & master_tready cycle.
REQ-027 Saturation: a run of exactly 2^cntw equal samples SHALL yield a count field of all ones; the next equal sample SHALL start a new run.

Reset
REQ-028 While reset=1: slave_tready=0, master_tvalid=0, master_tlast=0, master_tdata=0, word_count=0, and run_valid, pend_last and flush_pend all clear.
REQ-029 Reset asserted mid-run SHALL discard the open run and any slot contents without emitting them; the first accepted beat after release SHALL open a new run.

Verification
REQ-030 Samples 5,5,5,7 (last on 7), enable=1, master_tready=1 -> words {2,5} tlast=0, then {0,7} tlast=1; word_count=2.
REQ-031 cntw=2, eight samples of 0xA followed by 0xB with last -> {3,A}, {3,A}, {0,B} tlast=1.
REQ-032 enable=0, samples 1,1,1 with last on the third -> {0,1}, {0,1}, {0,1} with tlast only on the third word.
REQ-033 Samples 4,4, then a flush pulse -> {1,4} tlast=1; slave_tready=0 until that word is accepted; a second flush with no open run -> no word.
REQ-034 master_tready held low for 10 cycles with a word pending -> outputs stable and slave_tready=0 throughout; no data lost or duplicated after release.
REQ-035 Reset pulsed after samples 9,9 with no word yet emitted -> no word emitted; word_count=0; new sample 3 with last -> {0,3} tlast=1.
